// File: rtl/fetch_ifid_pkg.sv
// ----------------------------------------------------------------------------
// fetch_ifid_pkg
//
// Shared definitions for the fetch stage and IF/ID pipeline register:
//   - default reset PC and bubble instruction (addi x0,x0,0)
//   - PC increment per sequential fetch
//   - bit positions of the rs1/rs2 source-register fields in an instruction
//   - the IF/ID register record and the PC update selector
//   - rs_field(): extracts source field 0 (rs1) or 1 (rs2) from an instruction
// ----------------------------------------------------------------------------
package fetch_ifid_pkg;

    localparam logic [63:0] RESET_PC_DEFAULT  = 64'h0;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [63:0] PC_STEP           = 64'd4;

    localparam int REG_IDX_W = 5;
    localparam int RS1_LSB   = 15;
    localparam int RS1_MSB   = 19;
    localparam int RS2_LSB   = 20;
    localparam int RS2_MSB   = 24;
    localparam int NUM_SRC   = 2;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    // How the PC and IF/ID are updated on the next clock edge.
    typedef enum logic [1:0] {
        PC_ADVANCE  = 2'd0,
        PC_HOLD     = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    // Source register index idx (0 = rs1, 1 = rs2) of an instruction word.
    function automatic logic [REG_IDX_W-1:0] rs_field(input logic [31:0] instr,
                                                       input int          idx);
        logic [REG_IDX_W-1:0] f;
        if (idx == 0) begin
            f = instr[RS1_MSB:RS1_LSB];
        end else begin
            f = instr[RS2_MSB:RS2_LSB];
        end
        return f;
    endfunction

endpackage

// File: rtl/fetch_ifid_if.sv
// ----------------------------------------------------------------------------
// fetch_ifid_if
//
// Bundle of every non-clock/reset signal of the fetch stage.
//   instr_in        : instruction memory read data for pc_out (same cycle)
//   branch_taken    : redirect request from the branch-resolving stage
//   branch_target   : redirect address, meaningful when branch_taken=1
//   idex_memRead    : ID/EX currently holds a load
//   idex_rd         : destination register held in ID/EX
//   pc_out          : current fetch PC to instruction memory
//   ifid_pc_out     : PC of the instruction held in IF/ID
//   ifid_instr_out  : instruction held in IF/ID
//   ifid_valid_out  : IF/ID holds a real (non-bubble) instruction
//   stall_out       : ID/EX must latch a bubble because of a load-use hazard
//   flush_out       : ID/EX must latch a bubble because of a redirect
//
// master : the fetch stage (fetch_ifid)
// slave  : its surroundings (memory, decode/execute stages)
// ----------------------------------------------------------------------------
interface fetch_ifid_if;

    logic [31:0] instr_in;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        idex_memRead;
    logic [4:0]  idex_rd;

    logic [63:0] pc_out;
    logic [63:0] ifid_pc_out;
    logic [31:0] ifid_instr_out;
    logic        ifid_valid_out;
    logic        stall_out;
    logic        flush_out;

    modport master (
        input  instr_in,
        input  branch_taken,
        input  branch_target,
        input  idex_memRead,
        input  idex_rd,
        output pc_out,
        output ifid_pc_out,
        output ifid_instr_out,
        output ifid_valid_out,
        output stall_out,
        output flush_out
    );

    modport slave (
        output instr_in,
        output branch_taken,
        output branch_target,
        output idex_memRead,
        output idex_rd,
        input  pc_out,
        input  ifid_pc_out,
        input  ifid_instr_out,
        input  ifid_valid_out,
        input  stall_out,
        input  flush_out
    );

endinterface

// File: rtl/fetch_ifid_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
//
// Purely combinational load-use detector. Raises stall when the instruction
// in IF/ID reads (rs1 or rs2) the register that the load in ID/EX writes.
//   ifid_instr   in  32 : instruction held in IF/ID
//   ifid_valid   in   1 : IF/ID entry is real; bubbles never stall
//   idex_memRead in   1 : ID/EX holds a load
//   idex_rd      in   5 : destination of the instruction in ID/EX
//   stall        out  1 : load-use hazard present this cycle
// ----------------------------------------------------------------------------
module hazard_detect
    import fetch_ifid_pkg::*;
(
    input  logic [31:0]          ifid_instr,
    input  logic                 ifid_valid,
    input  logic                 idex_memRead,
    input  logic [REG_IDX_W-1:0] idex_rd,
    output logic                 stall
);

    logic [NUM_SRC-1:0] src_match;

    // One comparator per source operand field.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_match[gi] = (rs_field(ifid_instr, gi) == idex_rd);
        end
    endgenerate

    // x0 is hard-wired to zero, so a load into it can never be a dependency.
    assign stall = ifid_valid && idex_memRead && (idex_rd != '0) && (|src_match);

endmodule

// File: rtl/fetch_ifid.sv
// ----------------------------------------------------------------------------
// fetch_ifid
//
// Instruction fetch stage plus IF/ID pipeline register.
//   clk    : single clock, all state changes on its rising edge
//   reset  : synchronous, active-high; overrides redirect and stall
//   bus    : fetch_ifid_if.master (fetch data in, PC/IF/ID/stall/flush out)
//
// Parameters:
//   RESET_PC  : PC loaded on reset
//   NOP_INSTR : bubble instruction written into IF/ID on a redirect/reset
//
// Build option: define HAZARD_DETECT_EN to enable load-use stalling. Without
// it stall_out is constant 0, idex_memRead/idex_rd are ignored and the PC
// advances on every cycle that is not a redirect.
//
// Priority each cycle: reset > branch redirect > load-use hold > advance.
// ----------------------------------------------------------------------------
module fetch_ifid
    import fetch_ifid_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ifid_if.master bus
);

    logic [63:0] pc_reg;
    logic [63:0] pc_next;
    ifid_t       ifid_reg;
    ifid_t       ifid_next;
    logic        hazard;
    pc_sel_e     pc_sel;

`ifdef HAZARD_DETECT_EN
    hazard_detect u_hazard_detect (
        .ifid_instr   (ifid_reg.instr),
        .ifid_valid   (ifid_reg.valid),
        .idex_memRead (bus.idex_memRead),
        .idex_rd      (bus.idex_rd),
        .stall        (hazard)
    );
`else
    // Detection compiled out: the ID/EX load information is not needed.
    logic unused_idex;
    assign unused_idex = ^{bus.idex_memRead, bus.idex_rd};
    assign hazard      = 1'b0;
`endif

    // ---- state register ----------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            ifid_reg.pc    <= 64'h0;
            ifid_reg.instr <= NOP_INSTR;
            ifid_reg.valid <= 1'b0;
        end else begin
            pc_reg   <= pc_next;
            ifid_reg <= ifid_next;
        end
    end

    // ---- update selection --------------------------------------------------
    // A redirect wins over a hazard: the dependent instruction in IF/ID is on
    // the wrong path anyway and is replaced by a bubble.
    always_comb begin
        pc_sel = PC_ADVANCE;
        if (bus.branch_taken) begin
            pc_sel = PC_REDIRECT;
        end else if (hazard) begin
            pc_sel = PC_HOLD;
        end
    end

    // ---- next-state values -------------------------------------------------
    always_comb begin
        pc_next   = pc_reg;
        ifid_next = ifid_reg;
        case (pc_sel)
            PC_ADVANCE: begin
                // 64-bit add wraps naturally modulo 2^64.
                pc_next         = pc_reg + PC_STEP;
                ifid_next.pc    = pc_reg;
                ifid_next.instr = bus.instr_in;
                ifid_next.valid = 1'b1;
            end
            PC_REDIRECT: begin
                // Target taken as-is; no alignment check.
                pc_next         = bus.branch_target;
                ifid_next.pc    = pc_reg;
                ifid_next.instr = NOP_INSTR;
                ifid_next.valid = 1'b0;
            end
            PC_HOLD: begin
                pc_next   = pc_reg;
                ifid_next = ifid_reg;
            end
            default: begin
                pc_next   = pc_reg;
                ifid_next = ifid_reg;
            end
        endcase
    end

    // ---- outputs -----------------------------------------------------------
    always_comb begin
        bus.pc_out         = pc_reg;
        bus.ifid_pc_out    = ifid_reg.pc;
        bus.ifid_instr_out = ifid_reg.instr;
        bus.ifid_valid_out = ifid_reg.valid;
        // Reset already forces a clean pipeline, so neither bubble request
        // is raised while it is asserted.
        bus.stall_out      = (pc_sel == PC_HOLD) && !reset;
        bus.flush_out      = bus.branch_taken && !reset;
    end

endmodule

// File: tb/tb_fetch_ifid.sv
module tb_fetch_ifid;

    // Expected behaviour differs only where a load-use hazard exists.
`ifdef HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    localparam logic [31:0] I_ADDI = 32'h00A0_0093;  // addi x1,x0,10
    localparam logic [31:0] I_ADD  = 32'h0072_8333;  // add x6,x5,x7 (rs1=5, rs2=7)
    localparam logic [31:0] I_NOP  = 32'h0000_0013;

    typedef struct packed {
        logic        rst;
        logic [31:0] instr;
        logic        bt;
        logic [63:0] tgt;
        logic        mr;
        logic [4:0]  rd;
        logic        stall;   // expected combinational outputs before the edge
        logic        flush;
        logic [63:0] pc;      // expected registered outputs after the edge
        logic [63:0] ipc;
        logic [31:0] iinstr;
        logic        ivalid;
    } vector_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    vector_t vec[19];
    vector_t exp_q[$];

    fetch_ifid_if bus();

    fetch_ifid dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic vector_t mk(input logic rst, input logic [31:0] instr,
                                   input logic bt, input logic [63:0] tgt,
                                   input logic mr, input logic [4:0] rd,
                                   input logic stall, input logic flush,
                                   input logic [63:0] pc, input logic [63:0] ipc,
                                   input logic [31:0] iinstr, input logic ivalid);
        vector_t v;
        v.rst = rst; v.instr = instr; v.bt = bt; v.tgt = tgt; v.mr = mr; v.rd = rd;
        v.stall = stall; v.flush = flush; v.pc = pc; v.ipc = ipc;
        v.iinstr = iinstr; v.ivalid = ivalid;
        return v;
    endfunction

    function automatic logic [63:0] p64(input logic [63:0] with_hz, input logic [63:0] no_hz);
        return HZ ? with_hz : no_hz;
    endfunction

    function automatic logic [31:0] p32(input logic [31:0] with_hz, input logic [31:0] no_hz);
        return HZ ? with_hz : no_hz;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vector_t v, input string tag);
        vector_t e;
        @(negedge clk);
        reset             = v.rst;
        bus.instr_in      = v.instr;
        bus.branch_taken  = v.bt;
        bus.branch_target = v.tgt;
        bus.idex_memRead  = v.mr;
        bus.idex_rd       = v.rd;
        #1;
        check({tag, ".stall"}, 64'(bus.stall_out), 64'(v.stall));
        check({tag, ".flush"}, 64'(bus.flush_out), 64'(v.flush));
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.scoreboard: got empty queue, expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".pc"},     bus.pc_out,                e.pc);
            check({tag, ".ifid_pc"}, bus.ifid_pc_out,          e.ipc);
            check({tag, ".ifid_instr"}, 64'(bus.ifid_instr_out), 64'(e.iinstr));
            check({tag, ".ifid_valid"}, 64'(bus.ifid_valid_out), 64'(e.ivalid));
        end
        $display("txn %s rst=%0b bt=%0b mr=%0b rd=%0d | stall=%0b flush=%0b pc=%h ifid_pc=%h instr=%h v=%0b",
                 tag, v.rst, v.bt, v.mr, v.rd, bus.stall_out, bus.flush_out,
                 bus.pc_out, bus.ifid_pc_out, bus.ifid_instr_out, bus.ifid_valid_out);
    endtask

    initial begin
        reset             = 1'b1;
        bus.instr_in      = I_ADDI;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 64'h0;
        bus.idex_memRead  = 1'b0;
        bus.idex_rd       = 5'd0;

        //            rst instr   bt tgt                     mr rd  stall flush pc                     ipc                    iinstr               v
        vec[0]  = mk(1, I_ADDI, 0, 64'h0,                  0, 0,  0,    0,   64'h0,                 64'h0,                 I_NOP,               0);
        vec[1]  = mk(1, I_ADDI, 1, 64'h200,                1, 5,  0,    0,   64'h0,                 64'h0,                 I_NOP,               0);
        vec[2]  = mk(0, I_ADDI, 0, 64'h0,                  0, 0,  0,    0,   64'h4,                 64'h0,                 I_ADDI,              1);
        vec[3]  = mk(0, I_ADDI, 0, 64'h0,                  0, 0,  0,    0,   64'h8,                 64'h4,                 I_ADDI,              1);
        vec[4]  = mk(0, I_ADDI, 0, 64'h0,                  0, 0,  0,    0,   64'hC,                 64'h8,                 I_ADDI,              1);
        vec[5]  = mk(0, I_ADD,  0, 64'h0,                  0, 0,  0,    0,   64'h10,                64'hC,                 I_ADD,               1);
        vec[6]  = mk(0, I_ADDI, 0, 64'h0,                  1, 5,  HZ,   0,   p64(64'h10, 64'h14),   p64(64'hC, 64'h10),    p32(I_ADD, I_ADDI),  1);
        vec[7]  = mk(0, I_ADDI, 0, 64'h0,                  0, 0,  0,    0,   p64(64'h14, 64'h18),   p64(64'h10, 64'h14),   I_ADDI,              1);
        vec[8]  = mk(0, I_ADD,  0, 64'h0,                  0, 0,  0,    0,   p64(64'h18, 64'h1C),   p64(64'h14, 64'h18),   I_ADD,               1);
        vec[9]  = mk(0, I_ADDI, 0, 64'h0,                  1, 0,  0,    0,   p64(64'h1C, 64'h20),   p64(64'h18, 64'h1C),   I_ADDI,              1);
        vec[10] = mk(0, I_ADD,  0, 64'h0,                  0, 0,  0,    0,   p64(64'h20, 64'h24),   p64(64'h1C, 64'h20),   I_ADD,               1);
        vec[11] = mk(0, I_ADDI, 0, 64'h0,                  1, 7,  HZ,   0,   p64(64'h20, 64'h28),   p64(64'h1C, 64'h24),   p32(I_ADD, I_ADDI),  1);
        vec[12] = mk(0, I_ADDI, 0, 64'h0,                  0, 0,  0,    0,   p64(64'h24, 64'h2C),   p64(64'h20, 64'h28),   I_ADDI,              1);
        vec[13] = mk(0, I_ADD,  0, 64'h0,                  0, 0,  0,    0,   p64(64'h28, 64'h30),   p64(64'h24, 64'h2C),   I_ADD,               1);
        vec[14] = mk(0, I_ADDI, 1, 64'h100,                1, 5,  0,    1,   64'h100,               p64(64'h28, 64'h30),   I_NOP,               0);
        vec[15] = mk(0, I_ADDI, 0, 64'h0,                  1, 5,  0,    0,   64'h104,               64'h100,               I_ADDI,              1);
        vec[16] = mk(0, I_ADDI, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0,    1,   64'hFFFF_FFFF_FFFF_FFFC, 64'h104,             I_NOP,               0);
        vec[17] = mk(0, I_ADDI, 0, 64'h0,                  0, 0,  0,    0,   64'h0,                 64'hFFFF_FFFF_FFFF_FFFC, I_ADDI,            1);
        vec[18] = mk(0, I_ADDI, 0, 64'h0,                  0, 0,  0,    0,   64'h4,                 64'h0,                 I_ADDI,              1);

        for (int i = 0; i < 19; i++) begin
            apply(vec[i], $sformatf("vec%0d", i));
        end

        // Reset arriving while a load-use stall is in progress, together with
        // a redirect and the same hazard inputs: everything is discarded.
        apply(mk(0, I_ADD,  0, 64'h0,   0, 0, 0,  0, 64'h8, 64'h4, I_ADD, 1), "rst_stall.a");
        apply(mk(0, I_ADDI, 0, 64'h0,   1, 5, HZ, 0, p64(64'h8, 64'hC), p64(64'h4, 64'h8),
                 p32(I_ADD, I_ADDI), 1), "rst_stall.b");
        apply(mk(1, I_ADDI, 1, 64'h300, 1, 5, 0,  0, 64'h0, 64'h0, I_NOP, 0), "rst_stall.c");
        apply(mk(0, I_ADDI, 0, 64'h0,   0, 0, 0,  0, 64'h4, 64'h0, I_ADDI, 1), "rst_stall.d");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
